// File: rtl/hack_isa_pkg.sv
// Hack ISA constants: instruction field positions, datapath widths and a
// decoded-instruction view shared by the register/decode stage.
package hack_isa_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int PC_WIDTH   = 15;

  localparam int TYPE     = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int J_LT     = 2;
  localparam int J_EQ     = 1;
  localparam int J_GT     = 0;

  typedef enum logic {
    INSTR_A = 1'b0,
    INSTR_C = 1'b1
  } instr_kind_e;

  typedef struct packed {
    instr_kind_e kind;
    logic        a;
    logic [5:0]  comp;
    logic        dest_a;
    logic        dest_d;
    logic        dest_m;
    logic        j_lt;
    logic        j_eq;
    logic        j_gt;
  } decoded_t;

  // Pure field extraction; instr[14:13] carry no meaning for C-instructions.
  function automatic decoded_t decode(input logic [DATA_WIDTH-1:0] instr);
    decoded_t d;
    d.kind   = instr_kind_e'(instr[TYPE]);
    d.a      = instr[A_BIT];
    d.comp   = instr[COMP_MSB:COMP_LSB];
    d.dest_a = instr[DEST_A];
    d.dest_d = instr[DEST_D];
    d.dest_m = instr[DEST_M];
    d.j_lt   = instr[J_LT];
    d.j_eq   = instr[J_EQ];
    d.j_gt   = instr[J_GT];
    return d;
  endfunction

  // Jump resolution from the ALU flags; 3'b111 always takes.
  function automatic logic jump_taken(input decoded_t d, input logic zr,
                                      input logic ng);
    return (d.j_lt & ng) | (d.j_eq & zr) | (d.j_gt & ~zr & ~ng);
  endfunction

endpackage

// File: rtl/hack_pc.sv
// Program counter: async active-low clear, then load > inc > hold.
module hack_pc
  import hack_isa_pkg::*;
#(
  parameter int W = PC_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_next;

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = d;
    end else if (inc) begin
      q_next = q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU register/decode stage: owns A, D and PC, decodes the instruction
// into ALU controls/operands and writes back the ALU result.
module hack_cpu_ctrl
  import hack_isa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] in_m,
  output logic [DATA_WIDTH-1:0] alu_x,
  output logic [DATA_WIDTH-1:0] alu_y,
  output logic                  alu_zx,
  output logic                  alu_nx,
  output logic                  alu_zy,
  output logic                  alu_ny,
  output logic                  alu_f,
  output logic                  alu_no,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zr,
  input  logic                  alu_ng,
  output logic [DATA_WIDTH-1:0] out_m,
  output logic                  write_m,
  output logic [PC_WIDTH-1:0]   address_m,
  output logic [PC_WIDTH-1:0]   pc
);

  // instr_valid is a one-way qualifier with no ready: when high, instr is
  // consumed on this rising edge; when low, no architectural state changes
  // and no memory write is issued.

  decoded_t              dec;
  logic                  is_c;
  logic                  take;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] d_reg;
  logic [5:0]            ctrl;

  always_comb begin
    dec  = decode(instr);
    is_c = (dec.kind == INSTR_C);
    take = is_c & jump_taken(dec, alu_zr, alu_ng);
    ctrl = is_c ? dec.comp : 6'b000000;
  end

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

  assign alu_x     = d_reg;
  assign alu_y     = dec.a ? in_m : a_reg;
  assign out_m     = alu_out;
  assign address_m = a_reg[PC_WIDTH-1:0];
  // rst_n gates the strobe so no write can escape while reset is held.
  assign write_m   = rst_n & instr_valid & is_c & dec.dest_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
    end else if (instr_valid) begin
      if (!is_c) begin
        a_reg <= {1'b0, instr[PC_WIDTH-1:0]};
      end else if (dec.dest_a) begin
        a_reg <= alu_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg <= '0;
    end else if (instr_valid && is_c && dec.dest_d) begin
      d_reg <= alu_out;
    end
  end

  // Jump target is the pre-edge A, even when the same instruction writes A.
  hack_pc #(.W(PC_WIDTH)) u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (instr_valid & take),
    .inc   (instr_valid & ~take),
    .d     (a_reg[PC_WIDTH-1:0]),
    .q     (pc)
  );

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: reset checks, a table of hand-computed
// instruction vectors, and hand-written async reset sequences.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] in_m;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] out_m;
  logic        write_m;
  logic [14:0] address_m;
  logic [14:0] pc;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  hack_cpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .in_m        (in_m),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_zx      (alu_zx),
    .alu_nx      (alu_nx),
    .alu_zy      (alu_zy),
    .alu_ny      (alu_ny),
    .alu_f       (alu_f),
    .alu_no      (alu_no),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .out_m       (out_m),
    .write_m     (write_m),
    .address_m   (address_m),
    .pc          (pc)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic [15:0] in_m;
    logic [15:0] alu_out;
    logic        zr;
    logic        ng;
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  ctrl;
    logic        wm;
    logic [14:0] addr;
    logic [14:0] pc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mkv(logic [15:0] i, logic v, logic [15:0] m,
                               logic [15:0] ao, logic zr, logic ng,
                               logic [15:0] x, logic [15:0] y, logic [5:0] c,
                               logic wm, logic [14:0] addr, logic [14:0] p);
    vec_t r;
    r.instr = i; r.valid = v; r.in_m = m; r.alu_out = ao; r.zr = zr; r.ng = ng;
    r.x = x; r.y = y; r.ctrl = c; r.wm = wm; r.addr = addr; r.pc = p;
    return r;
  endfunction

  // scoreboard: expected value is queued, then popped against the actual
  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    logic [15:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic v, input logic [15:0] m,
                       input logic [15:0] ao, input logic zr, input logic ng);
    instr = i; instr_valid = v; in_m = m; alu_out = ao; alu_zr = zr; alu_ng = ng;
  endtask

  task automatic check_vec(input int n, input vec_t t);
    string s;
    s = $sformatf("v%0d", n);
    chk({s, ".alu_x"}, alu_x, t.x);
    chk({s, ".alu_y"}, alu_y, t.y);
    chk({s, ".ctrl"}, {10'd0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no},
        {10'd0, t.ctrl});
    chk({s, ".write_m"}, {15'd0, write_m}, {15'd0, t.wm});
    chk({s, ".out_m"}, out_m, t.alu_out);
    chk({s, ".address_m"}, {1'b0, address_m}, {1'b0, t.addr});
    chk({s, ".pc"}, {1'b0, pc}, {1'b0, t.pc});
  endtask

  initial begin
    //        instr    v     in_m     alu_out  zr    ng    x        y        ctrl   wm    addr       pc
    vecs[0]  = mkv(16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'h00, 1'b0, 15'h0000, 15'h0000);
    vecs[1]  = mkv(16'hEC10, 1'b1, 16'h0000, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0005, 6'h30, 1'b0, 15'h0005, 15'h0001);
    vecs[2]  = mkv(16'h0007, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0005, 16'h0005, 6'h00, 1'b0, 15'h0005, 15'h0002);
    vecs[3]  = mkv(16'hEC10, 1'b1, 16'h0000, 16'h0007, 1'b0, 1'b0, 16'h0005, 16'h0007, 6'h30, 1'b0, 15'h0007, 15'h0003);
    vecs[4]  = mkv(16'h0064, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0007, 6'h00, 1'b0, 15'h0007, 15'h0004);
    vecs[5]  = mkv(16'hE308, 1'b1, 16'h0000, 16'h0007, 1'b0, 1'b0, 16'h0007, 16'h0064, 6'h0C, 1'b1, 15'h0064, 15'h0005);
    vecs[6]  = mkv(16'h0014, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0064, 6'h00, 1'b0, 15'h0064, 15'h0006);
    vecs[7]  = mkv(16'hE304, 1'b1, 16'h0000, 16'h0007, 1'b0, 1'b1, 16'h0007, 16'h0014, 6'h0C, 1'b0, 15'h0014, 15'h0007);
    vecs[8]  = mkv(16'hE304, 1'b1, 16'h0000, 16'h0007, 1'b0, 1'b0, 16'h0007, 16'h0014, 6'h0C, 1'b0, 15'h0014, 15'h0014);
    vecs[9]  = mkv(16'hEA87, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0014, 6'h2A, 1'b0, 15'h0014, 15'h0015);
    vecs[10] = mkv(16'hE302, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0007, 16'h0014, 6'h0C, 1'b0, 15'h0014, 15'h0014);
    vecs[11] = mkv(16'hE301, 1'b1, 16'h0000, 16'h0005, 1'b0, 1'b0, 16'h0007, 16'h0014, 6'h0C, 1'b0, 15'h0014, 15'h0014);
    vecs[12] = mkv(16'hE301, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0007, 16'h0014, 6'h0C, 1'b0, 15'h0014, 15'h0014);
    vecs[13] = mkv(16'h001E, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0014, 6'h00, 1'b0, 15'h0014, 15'h0015);
    vecs[14] = mkv(16'hFDEF, 1'b1, 16'h0008, 16'h0009, 1'b0, 1'b0, 16'h0007, 16'h0008, 6'h37, 1'b1, 15'h001E, 15'h0016);
    vecs[15] = mkv(16'hFDEF, 1'b0, 16'h0008, 16'h1234, 1'b0, 1'b0, 16'h0007, 16'h0008, 6'h37, 1'b0, 15'h0009, 15'h001E);
    vecs[16] = mkv(16'hEC10, 1'b0, 16'h0008, 16'h1234, 1'b0, 1'b0, 16'h0007, 16'h0009, 6'h30, 1'b0, 15'h0009, 15'h001E);
    vecs[17] = mkv(16'hEC10, 1'b0, 16'h0008, 16'h1234, 1'b1, 1'b1, 16'h0007, 16'h0009, 6'h30, 1'b0, 15'h0009, 15'h001E);
    vecs[18] = mkv(16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0009, 6'h00, 1'b0, 15'h0009, 15'h001E);
    vecs[19] = mkv(16'h7FFF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0000, 6'h00, 1'b0, 15'h0000, 15'h001F);
    vecs[20] = mkv(16'hEA87, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h7FFF, 6'h2A, 1'b0, 15'h7FFF, 15'h0020);
    vecs[21] = mkv(16'h0003, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h7FFF, 6'h00, 1'b0, 15'h7FFF, 15'h7FFF);
    vecs[22] = mkv(16'hEC10, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0003, 6'h30, 1'b0, 15'h0003, 15'h0000);
    vecs[23] = mkv(16'hEC10, 1'b1, 16'h0000, 16'h0042, 1'b0, 1'b0, 16'h0007, 16'h0003, 6'h30, 1'b0, 15'h0003, 15'h0000);

    // reset held with a writing, jumping C-instruction presented
    rst_n = 1'b0;
    drive(16'hFFFF, 1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    #3;
    chk("rst.pc", {1'b0, pc}, 16'h0000);
    chk("rst.write_m", {15'd0, write_m}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edge.pc", {1'b0, pc}, 16'h0000);
    chk("rst_edge.alu_x", alu_x, 16'h0000);
    chk("rst_edge.write_m", {15'd0, write_m}, 16'h0000);
    drive(16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("post_rst.alu_x", alu_x, 16'h0000);
    chk("post_rst.alu_y", alu_y, 16'h0000);
    chk("post_rst.address_m", {1'b0, address_m}, 16'h0000);
    chk("post_rst.pc", {1'b0, pc}, 16'h0000);
    @(posedge clk);
    #1;

    // table: drive, check combinational outputs mid-cycle, then clock
    for (int n = 0; n < 24; n++) begin
      drive(vecs[n].instr, vecs[n].valid, vecs[n].in_m, vecs[n].alu_out,
            vecs[n].zr, vecs[n].ng);
      #2;
      check_vec(n, vecs[n]);
      @(posedge clk);
      #1;
    end

    // effects of the last vector: D = 0x42, pc = 1
    drive(16'hE308, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("pre_arst.alu_x", alu_x, 16'h0042);
    chk("pre_arst.pc", {1'b0, pc}, 16'h0001);

    // async reset pulse mid-cycle with a valid M write on the bus
    drive(16'hFDEF, 1'b1, 16'h0000, 16'h0055, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.alu_x", alu_x, 16'h0000);
    chk("arst.address_m", {1'b0, address_m}, 16'h0000);
    chk("arst.pc", {1'b0, pc}, 16'h0000);
    chk("arst.write_m", {15'd0, write_m}, 16'h0000);
    @(posedge clk);
    #1;
    chk("arst_edge.pc", {1'b0, pc}, 16'h0000);
    rst_n = 1'b1;
    drive(16'h0011, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("first.pc", {1'b0, pc}, 16'h0000);
    @(posedge clk);
    #1;
    chk("first_after.pc", {1'b0, pc}, 16'h0001);
    chk("first_after.address_m", {1'b0, address_m}, 16'h0011);
    chk("first_after.alu_x", alu_x, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
